// File: rtl/fsm_ring_sequencer.sv
// ---------------------------------------------------------------------------
// fsm_ring_sequencer
//
// This module owns the state register of an NSTATES-deep ring FSM
// (0 -> 1 -> ... -> NSTATES-1 -> 0). Each state is held for a programmable
// dwell time. After the dwell expires, the ring leaves state k only when
// go_i[k] is high. A small run/stop controller starts the ring. It can also
// drain the ring back to state 0 and park it there.
//
// Optional feature: define SEQ_HOLD_EN to add the hold_i input. While hold_i
// is high, the dwell counter is frozen and no advance can happen.
//
// Ports
//   clock_i       rising-edge clock
//   reset_i       synchronous, active-high reset (also clears dwell table)
//   start_i       level: start the ring, or resume it while draining
//   stop_i        level: request a drain back to state 0
//   go_i          go_i[k] allows an advance out of state k
//   hold_i        (SEQ_HOLD_EN only) freeze counter and block advance
//   cfg_we_i      dwell table write strobe
//   cfg_addr_i    dwell table index (values >= NSTATES are ignored)
//   cfg_dwell_i   dwell value; state k is held >= dwell[k]+1 cycles
//   state_o       current ring state (registered)
//   busy_o        1 while the controller is in RUN or STOPPING
//   adv_o         1-cycle pulse in the first cycle of a newly entered state
//   wrap_o        1-cycle pulse together with adv_o when the new state is 0
// ---------------------------------------------------------------------------
//   ctl       | meaning
//   ----------+--------------------------------------------------------------
//   CTL_IDLE  | ring parked at state 0, waiting for start_i
//   CTL_RUN   | ring stepping; stop_i begins a drain
//   CTL_STOP  | ring stepping until it wraps to 0, then back to idle
// ---------------------------------------------------------------------------
module fsm_ring_sequencer #(
    parameter int NSTATES = 9,
    parameter int SW      = 4,
    parameter int DW      = 8
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [NSTATES-1:0] go_i,
`ifdef SEQ_HOLD_EN
    input  logic               hold_i,
`endif
    input  logic               cfg_we_i,
    input  logic [SW-1:0]      cfg_addr_i,
    input  logic [DW-1:0]      cfg_dwell_i,
    output logic [SW-1:0]      state_o,
    output logic               busy_o,
    output logic               adv_o,
    output logic               wrap_o
);

    typedef enum logic [1:0] {
        CTL_IDLE = 2'd0,
        CTL_RUN  = 2'd1,
        CTL_STOP = 2'd2
    } ctl_t;

    localparam logic [SW-1:0] LAST = SW'(NSTATES - 1);

    ctl_t          ctl_q, ctl_d;
    logic [SW-1:0] state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          busy_q, adv_q, adv_d, wrap_q, wrap_d;
    logic [DW-1:0] dwell_q [NSTATES];

    logic          hold;
    logic [SW-1:0] nxt;
    logic          step;
    logic          addr_ok;

`ifdef SEQ_HOLD_EN
    assign hold = hold_i;
`else
    assign hold = 1'b0;
`endif

    assign nxt     = (state_q == LAST) ? '0 : state_q + SW'(1);
    assign step    = (ctl_q != CTL_IDLE) && !hold && (cnt_q == '0) && go_i[state_q];
    // Widen by one bit so that NSTATES == 2**SW still compares correctly.
    assign addr_ok = {1'b0, cfg_addr_i} < (SW+1)'(NSTATES);

    always_comb begin
        ctl_d   = ctl_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        adv_d   = 1'b0;
        wrap_d  = 1'b0;

        if (ctl_q == CTL_IDLE) begin
            state_d = '0;
            if (start_i) begin
                ctl_d = CTL_RUN;
                cnt_d = dwell_q[0];
            end
        end else if (!hold) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - DW'(1);
            end else if (go_i[state_q]) begin
                state_d = nxt;
                // The table is read before this cycle's write lands, so a
                // load and a write of the same entry take the old value.
                cnt_d   = dwell_q[nxt];
                adv_d   = 1'b1;
                wrap_d  = (nxt == '0);
            end
        end

        case (ctl_q)
            CTL_RUN: begin
                if (stop_i) ctl_d = CTL_STOP;
            end
            CTL_STOP: begin
                if (start_i && !stop_i)      ctl_d = CTL_RUN;
                else if (step && nxt == '0)  ctl_d = CTL_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ctl_q   <= CTL_IDLE;
            state_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            adv_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            ctl_q   <= ctl_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (ctl_d != CTL_IDLE);
            adv_q   <= adv_d;
            wrap_q  <= wrap_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int k = 0; k < NSTATES; k++) dwell_q[k] <= '0;
        end else if (cfg_we_i && addr_ok) begin
            dwell_q[cfg_addr_i] <= cfg_dwell_i;
        end
    end

    assign state_o = state_q;
    assign busy_o  = busy_q;
    assign adv_o   = adv_q;
    assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_fsm_ring_sequencer.sv
module tb_fsm_ring_sequencer;

    localparam int NS = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [NS-1:0] go = '1;
    logic          hold = 1'b0;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_addr = '0;
    logic [7:0]    cfg_dwell = '0;
    logic [3:0]    state;
    logic          busy, adv, wrap;

    fsm_ring_sequencer #(.NSTATES(NS), .SW(4), .DW(8)) dut (
        .clock_i     (clk),
        .reset_i     (reset),
        .start_i     (start),
        .stop_i      (stop),
        .go_i        (go),
`ifdef SEQ_HOLD_EN
        .hold_i      (hold),
`endif
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_dwell_i (cfg_dwell),
        .state_o     (state),
        .busy_o      (busy),
        .adv_o       (adv),
        .wrap_o      (wrap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int st;
        bit wr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Scoreboard monitor: every adv pulse must match the next expected entry
    // in cycle, state and wrap; expected entries that go unmatched are flagged.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL adv_missing cyc=%0d expected state=%0d at cyc=%0d, got state=%0d", cyc, e.st, e.cyc, state);
        end
        if (adv === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL adv_unexpected cyc=%0d state=%0d wrap=%0b", cyc, state, wrap);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || int'(state) != e.st || wrap !== e.wr) begin
                    errors++;
                    $display("FAIL adv_event got cyc=%0d state=%0d wrap=%0b, expected cyc=%0d state=%0d wrap=%0b",
                             cyc, state, wrap, e.cyc, e.st, e.wr);
                end
            end
        end else if (wrap === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wrap_without_adv cyc=%0d state=%0d", cyc, state);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic cfg_wr(input int a, input int d);
        cfg_we = 1'b1;
        cfg_addr = 4'(a);
        cfg_dwell = 8'(d);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic push(input int c, input int s, input bit w);
        exp_t e;
        e.cyc = c;
        e.st = s;
        e.wr = w;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, expv);
        end
    endtask

    // One-pass ring with every dwell at 0, start sampled at edge c+1.
    task automatic push_full_ring(input int c);
        for (int k = 1; k < NS; k++) push(c + 1 + k, k, 1'b0);
        push(c + 10, 0, 1'b1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;

        // 1: reset then idle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk("idle_state", int'(state), 0);
            chk("idle_busy", int'(busy), 0);
            chk("idle_adv", int'(adv), 0);
            chk("idle_wrap", int'(wrap), 0);
            tick();
        end

        // 2: all dwell 0, one state per cycle
        go = '1;
        c = cyc;
        push_full_ring(c);
        pulse_start();
        chk("start_busy", int'(busy), 1);
        chk("start_state", int'(state), 0);
        wait_cyc(c + 10);
        chk("ring_wrap_state", int'(state), 0);
        chk("ring_busy_run", int'(busy), 1);
        do_reset();

        // 3: dwell[3]=4 holds state 3 for five cycles; rewriting the entry
        //    while in state 3 does not touch the running count
        cfg_wr(3, 4);
        c = cyc;
        push(c + 2, 1, 1'b0);
        push(c + 3, 2, 1'b0);
        push(c + 4, 3, 1'b0);
        push(c + 9, 4, 1'b0);
        push(c + 10, 5, 1'b0);
        push(c + 11, 6, 1'b0);
        push(c + 12, 7, 1'b0);
        push(c + 13, 8, 1'b0);
        push(c + 14, 0, 1'b1);
        pulse_start();
        wait_cyc(c + 5);
        cfg_wr(3, 0);
        wait_cyc(c + 8);
        chk("dwell3_last_cycle", int'(state), 3);
        wait_cyc(c + 14);
        do_reset();

        // 4: go[5]=0 parks the ring at 5
        go = 9'h1DF;
        c = cyc;
        for (int k = 1; k <= 5; k++) push(c + 1 + k, k, 1'b0);
        pulse_start();
        wait_cyc(c + 14);
        chk("park_state", int'(state), 5);
        chk("park_adv", int'(adv), 0);
        chk("park_busy", int'(busy), 1);
        go = '1;
        push(c + 15, 6, 1'b0);
        push(c + 16, 7, 1'b0);
        push(c + 17, 8, 1'b0);
        push(c + 18, 0, 1'b1);
        wait_cyc(c + 18);
        do_reset();

        // 5a: stop at state 4 drains through 5..8 to 0 and goes idle
        c = cyc;
        push_full_ring(c);
        pulse_start();
        wait_cyc(c + 5);
        chk("stop_at_state", int'(state), 4);
        stop = 1'b1;
        wait_cyc(c + 10);
        chk("drain_wrap_state", int'(state), 0);
        chk("drain_busy", int'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drained_state", int'(state), 0);
            chk("drained_busy", int'(busy), 0);
        end
        stop = 1'b0;

        // 5b: start and stop together in RUN means drain
        c = cyc;
        push_full_ring(c);
        start = 1'b1;
        tick();
        stop = 1'b1;
        wait_cyc(c + 5);
        start = 1'b0;
        stop = 1'b0;
        wait_cyc(c + 10);
        chk("startstop_busy", int'(busy), 0);
        tick();
        tick();
        chk("startstop_state", int'(state), 0);
        chk("startstop_busy_after", int'(busy), 0);
        do_reset();

        // 6: out-of-range writes ignored; reset mid-run clears the table too
        cfg_wr(9, 5);
        cfg_wr(15, 7);
        cfg_wr(2, 3);
        c = cyc;
        push(c + 2, 1, 1'b0);
        push(c + 3, 2, 1'b0);
        push(c + 7, 3, 1'b0);
        push(c + 8, 4, 1'b0);
        push(c + 9, 5, 1'b0);
        push(c + 10, 6, 1'b0);
        pulse_start();
        wait_cyc(c + 10);
        chk("pre_reset_state", int'(state), 6);
        reset = 1'b1;
        tick();
        chk("midrun_reset_state", int'(state), 0);
        chk("midrun_reset_busy", int'(busy), 0);
        chk("midrun_reset_adv", int'(adv), 0);
        reset = 1'b0;
        c = cyc;
        push_full_ring(c);
        pulse_start();
        wait_cyc(c + 10);
        do_reset();

`ifdef SEQ_HOLD_EN
        // hold for three cycles in state 2 freezes the count
        cfg_wr(2, 2);
        c = cyc;
        push(c + 2, 1, 1'b0);
        push(c + 3, 2, 1'b0);
        push(c + 9, 3, 1'b0);
        pulse_start();
        wait_cyc(c + 3);
        hold = 1'b1;
        wait_cyc(c + 6);
        chk("hold_state", int'(state), 2);
        hold = 1'b0;
        wait_cyc(c + 8);
        chk("hold_release_state", int'(state), 2);
        wait_cyc(c + 9);
        do_reset();
`endif

        tick();
        tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
